// File: rtl/test_pattern_sequencer.sv
// Frame-synchronous test pattern selector: manual next/prev steps plus optional
// auto-cycling (build with AUTO_CYCLE_EN). Pattern changes land only on VSync rising edges.
module test_pattern_sequencer #(
  parameter logic [3:0] MIN_PATTERN   = 4'd1,
  parameter logic [3:0] MAX_PATTERN   = 4'd6,
  parameter logic [3:0] RESET_PATTERN = 4'd1,
  parameter int         DWELL_FRAMES  = 120
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_VSync,
  input  logic       i_Next,
  input  logic       i_Prev,
  input  logic       i_Auto,
  output logic [3:0] o_Pattern,
  output logic       o_Frame_Pulse,
  output logic       o_Changed,
  output logic       o_Pending,
  output logic       o_Auto_Active
);

  localparam logic [9:0] DWELL_LAST = 10'(DWELL_FRAMES - 1);

  function automatic logic [3:0] step_pat(input logic [3:0] p, input logic up);
    if (up) return (p == MAX_PATTERN) ? MIN_PATTERN : p + 4'd1;
    else    return (p == MIN_PATTERN) ? MAX_PATTERN : p - 4'd1;
  endfunction

  logic       vsync_prev;
  logic       pend_up;
  logic       fb;
  logic       req_valid;
  logic       dwell_hit;
  logic       apply;
  logic [3:0] next_pat;

  assign fb        = i_VSync & ~vsync_prev;
  assign req_valid = i_Next ^ i_Prev;
  // A pending manual step outranks dwell expiry; both only ever step by one.
  assign apply     = fb & (o_Pending | dwell_hit);
  assign next_pat  = apply ? step_pat(o_Pattern, o_Pending ? pend_up : 1'b1) : o_Pattern;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      vsync_prev    <= 1'b1;
      o_Pattern     <= RESET_PATTERN;
      o_Frame_Pulse <= 1'b0;
      o_Changed     <= 1'b0;
      o_Pending     <= 1'b0;
      pend_up       <= 1'b0;
    end else begin
      vsync_prev    <= i_VSync;
      o_Frame_Pulse <= fb;
      o_Changed     <= apply & (next_pat != o_Pattern);
      o_Pattern     <= next_pat;
      // A request on a boundary edge is kept for the following boundary.
      if (req_valid) begin
        o_Pending <= 1'b1;
        pend_up   <= i_Next;
      end else if (fb) begin
        o_Pending <= 1'b0;
      end
    end
  end

`ifdef AUTO_CYCLE_EN
  typedef enum logic {MANUAL, AUTO} seq_state_t;

  seq_state_t state;
  logic [9:0] frame_cnt;

  assign dwell_hit = (state == AUTO) & i_Auto & (frame_cnt == DWELL_LAST);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state         <= MANUAL;
      frame_cnt     <= '0;
      o_Auto_Active <= 1'b0;
    end else begin
      case (state)
        MANUAL: begin
          frame_cnt <= '0;
          if (i_Auto) begin
            state         <= AUTO;
            o_Auto_Active <= 1'b1;
          end
        end
        AUTO: begin
          if (!i_Auto) begin
            state         <= MANUAL;
            o_Auto_Active <= 1'b0;
            frame_cnt     <= '0;
          end else if (fb) begin
            if (o_Pending || frame_cnt == DWELL_LAST) frame_cnt <= '0;
            else                                      frame_cnt <= frame_cnt + 10'd1;
          end
        end
        default: state <= MANUAL;
      endcase
    end
  end
`else
  logic unused_auto;
  assign unused_auto   = i_Auto;
  assign dwell_hit     = 1'b0;
  assign o_Auto_Active = 1'b0;
`endif

endmodule

// File: tb/tb_test_pattern_sequencer.sv
// Directed bench for test_pattern_sequencer with a cycle model; auto-mode
// section is active when built with AUTO_CYCLE_EN.
module tb_test_pattern_sequencer;
  localparam int MINP  = 1;
  localparam int MAXP  = 6;
  localparam int RSTP  = 1;
  localparam int DWELL = 3;

  logic       i_Clk = 1'b0, i_Rst = 1'b0, i_VSync = 1'b1;
  logic       i_Next = 1'b0, i_Prev = 1'b0, i_Auto = 1'b0;
  logic [3:0] o_Pattern;
  logic       o_Frame_Pulse, o_Changed, o_Pending, o_Auto_Active;

  test_pattern_sequencer #(
    .MIN_PATTERN(4'(MINP)), .MAX_PATTERN(4'(MAXP)),
    .RESET_PATTERN(4'(RSTP)), .DWELL_FRAMES(DWELL)
  ) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_VSync(i_VSync), .i_Next(i_Next),
    .i_Prev(i_Prev), .i_Auto(i_Auto), .o_Pattern(o_Pattern),
    .o_Frame_Pulse(o_Frame_Pulse), .o_Changed(o_Changed),
    .o_Pending(o_Pending), .o_Auto_Active(o_Auto_Active)
  );

  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pattern as an index into the ring [MINP..MAXP]; pending step as a signed int.
  int m_pat, m_pend, m_frames, m_step, m_new;
  bit m_vs, m_auto, m_fp, m_chg, m_fb;

  function automatic int ring_step(input int p, input int d);
    int n = MAXP - MINP + 1;
    return MINP + ((p - MINP + d + n) % n);
  endfunction

  always @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      m_pat = RSTP; m_pend = 0; m_frames = 0; m_vs = 1; m_auto = 0; m_fp = 0; m_chg = 0;
    end else begin
      m_fb   = i_VSync && !m_vs;
      m_vs   = i_VSync;
      m_step = 0;
      if (m_fb) begin
        if (m_pend != 0) m_step = m_pend;
`ifdef AUTO_CYCLE_EN
        else if (m_auto && i_Auto && m_frames == DWELL - 1) m_step = 1;
`endif
      end
`ifdef AUTO_CYCLE_EN
      if (!m_auto) begin
        m_frames = 0;
        m_auto   = i_Auto;
      end else if (!i_Auto) begin
        m_auto = 0; m_frames = 0;
      end else if (m_fb) begin
        m_frames = (m_step != 0) ? 0 : m_frames + 1;
      end
`endif
      m_new = (m_step != 0) ? ring_step(m_pat, m_step) : m_pat;
      m_chg = m_fb && (m_new != m_pat);
      m_fp  = m_fb;
      m_pat = m_new;
      if (i_Next && !i_Prev)      m_pend = 1;
      else if (i_Prev && !i_Next) m_pend = -1;
      else if (m_fb)              m_pend = 0;
    end
  end

  always @(negedge i_Clk) begin
    if (chk_en && !i_Rst) begin
      check("m_pattern", o_Pattern, m_pat);
      check("m_frame_pulse", o_Frame_Pulse, m_fp);
      check("m_changed", o_Changed, m_chg);
      check("m_pending", o_Pending, m_pend != 0);
      check("m_auto_active", o_Auto_Active, m_auto);
    end
  end

  logic [3:0] fb_pat;
  logic       fb_chg, fb_fp, fb_pend;

  task automatic cyc(input bit vs, input bit nx, input bit pv);
    i_VSync = vs; i_Next = nx; i_Prev = pv;
    @(negedge i_Clk);
  endtask

  // One frame: 2 blanking cycles, the boundary cycle, then 3 active rows with an optional request.
  task automatic frame(input bit nx, input bit pv);
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
    fb_pat = o_Pattern; fb_chg = o_Changed; fb_fp = o_Frame_Pulse; fb_pend = o_Pending;
    cyc(1, nx, pv); cyc(1, 0, 0); cyc(1, 0, 0);
  endtask

  initial begin
    #1 i_Rst = 1'b1;
    @(negedge i_Clk);
    check("rst_pattern", o_Pattern, 1);
    check("rst_frame_pulse", o_Frame_Pulse, 0);
    check("rst_changed", o_Changed, 0);
    check("rst_pending", o_Pending, 0);
    check("rst_auto", o_Auto_Active, 0);
    i_Rst = 1'b0;
    chk_en = 1'b1;
    // VSync already high at release: no boundary.
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
    check("no_false_fb", o_Frame_Pulse, 0);
    check("hold_after_rst", o_Pattern, 1);

    frame(1, 0);
    check("fb1_pulse", fb_fp, 1);
    check("fb1_nochange", fb_chg, 0);
    check("next_pending", o_Pending, 1);
    check("next_waits", o_Pattern, 1);
    frame(1, 0);
    check("next_applied", fb_pat, 2);
    check("next_changed", fb_chg, 1);
    check("next_consumed", fb_pend, 0);
    for (int k = 3; k <= 6; k++) begin
      frame(1, 0);
      check("step_up", fb_pat, k);
    end
    frame(0, 1);
    check("wrap_up", fb_pat, 1);
    frame(1, 1);
    check("wrap_down", fb_pat, 6);
    check("both_ignored", o_Pending, 0);
    frame(0, 0);
    check("both_no_change", fb_chg, 0);
    check("both_hold", fb_pat, 6);

    // Next then Prev in one frame: last request wins.
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 0, 1); cyc(1, 0, 0);
    frame(0, 0);
    check("last_wins", fb_pat, 5);
    check("last_wins_chg", fb_chg, 1);

    // Request on the boundary edge itself waits a frame.
    cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 1, 0);
    check("same_edge_fp", o_Frame_Pulse, 1);
    check("same_edge_hold", o_Pattern, 5);
    check("same_edge_pend", o_Pending, 1);
    cyc(1, 0, 0); cyc(1, 0, 0);
    frame(0, 0);
    check("same_edge_next", fb_pat, 6);

    i_Auto = 1'b1;
`ifdef AUTO_CYCLE_EN
    frame(0, 0); check("auto_f1", fb_pat, 6);
    check("auto_active", o_Auto_Active, 1);
    frame(0, 0); check("auto_f2", fb_pat, 6);
    frame(0, 0); check("auto_f3", fb_pat, 1);
    frame(1, 0); check("auto_f4", fb_pat, 1);
    frame(0, 0); check("auto_manual", fb_pat, 2);
    frame(0, 0); check("auto_restart1", fb_pat, 2);
    frame(0, 0); check("auto_restart2", fb_pat, 2);
    frame(0, 0); check("auto_restart3", fb_pat, 3);
    frame(1, 0); check("auto_pre_rst", fb_pat, 3);
`else
    frame(0, 0); check("noauto_f1", fb_pat, 6);
    frame(0, 0); check("noauto_f2", fb_pat, 6);
    check("noauto_inactive", o_Auto_Active, 0);
    frame(1, 0); check("noauto_pre_rst", fb_pat, 6);
`endif
    check("pre_rst_pending", o_Pending, 1);

    // Asynchronous reset in the middle of a cycle.
    #2 i_Rst = 1'b1;
    #1;
    check("arst_pattern", o_Pattern, 1);
    check("arst_pending", o_Pending, 0);
    check("arst_auto", o_Auto_Active, 0);
    check("arst_fp", o_Frame_Pulse, 0);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    cyc(1, 0, 0);
`ifdef AUTO_CYCLE_EN
    check("reenter_auto", o_Auto_Active, 1);
`else
    check("reenter_auto", o_Auto_Active, 0);
`endif
    check("post_rst_no_fb", o_Frame_Pulse, 0);
    frame(0, 0);
    check("post_rst_fb", fb_fp, 1);
    check("post_rst_pat", fb_pat, 1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end
endmodule
